multicycle_controller: RTL and testbench

- Control unit for the multicycle MIPS core; sits directly upstream of the datapath.
- Consumes op, funct and zero from the datapath and drives every datapath enable and mux select.
- Moore main FSM sequences each instruction over 3–5 cycles; a combinational ALU decoder sub-block produces alucontrol.
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

---
 rtl/multicycle_controller_pkg.sv | 49 ++++
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/multicycle_controller_aludec.sv | 36 +++
 rtl/multicycle_controller.sv | 128 ++++++++++++
 tb/tb_multicycle_controller.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Purpose : Shared encodings for the multicycle MIPS controller.
//           Covers FSM states, opcodes, functs, ALU op classes and ALU codes.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [3:0] C_FETCH   = 4'd0;
    localparam logic [3:0] C_DECODE  = 4'd1;
    localparam logic [3:0] C_MEMADR  = 4'd2;
    localparam logic [3:0] C_MEMRD   = 4'd3;
    localparam logic [3:0] C_MEMWB   = 4'd4;
    localparam logic [3:0] C_MEMWR   = 4'd5;
    localparam logic [3:0] C_RTYPEEX = 4'd6;
    localparam logic [3:0] C_RTYPEWB = 4'd7;
    localparam logic [3:0] C_BEQEX   = 4'd8;
    localparam logic [3:0] C_ADDIEX  = 4'd9;
    localparam logic [3:0] C_ADDIWB  = 4'd10;
    localparam logic [3:0] C_JEX     = 4'd11;

    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    localparam logic [5:0] C_FUNCT_ADD = 6'b100000;
    localparam logic [5:0] C_FUNCT_SUB = 6'b100010;
    localparam logic [5:0] C_FUNCT_AND = 6'b100100;
    localparam logic [5:0] C_FUNCT_OR  = 6'b100101;
    localparam logic [5:0] C_FUNCT_SLT = 6'b101010;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module  : mc_ctrl_if
// Purpose : Controller <-> datapath bundle; master = controller side.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
               regdst, alusrcb, pcsrc, alucontrol, state
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller_aludec.sv
// ============================================================================
// Module  : aludec
// Purpose : Combinational ALU decoder, (aluop, funct) -> alucontrol.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module aludec
    import mc_ctrl_pkg::*;
(
    input  wire logic [1:0] aluop,
    input  wire logic [5:0] funct,
    output logic      [2:0] alucontrol
);

    always_comb begin
        alucontrol = C_ALU_ADD;
        case (aluop)
            C_ALUOP_SUB: alucontrol = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (funct)
                    C_FUNCT_ADD: alucontrol = C_ALU_ADD;
                    C_FUNCT_SUB: alucontrol = C_ALU_SUB;
                    C_FUNCT_AND: alucontrol = C_ALU_AND;
                    C_FUNCT_OR:  alucontrol = C_ALU_OR;
                    C_FUNCT_SLT: alucontrol = C_ALU_SLT;
                    default:     alucontrol = C_ALU_ADD;
                endcase
            end
            default: alucontrol = C_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module  : multicycle_controller
// Purpose : Moore control FSM for the multicycle MIPS datapath.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    mc_ctrl_if.master  bus
);

    logic [3:0] state_q, state_d;
    logic       pcwrite, branch, memwrite, irwrite, regwrite;
    logic       alusrca, iord, memtoreg, regdst, legal_state;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [2:0] aludec_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= C_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = C_FETCH;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = C_ALUOP_ADD;
        legal_state = 1'b1;
        case (state_q)
            C_FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = C_DECODE;
            end
            C_DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    C_OP_LW, C_OP_SW: state_d = C_MEMADR;
                    C_OP_RTYPE:       state_d = C_RTYPEEX;
                    C_OP_BEQ:         state_d = C_BEQEX;
                    C_OP_ADDI:        state_d = C_ADDIEX;
                    C_OP_J:           state_d = C_JEX;
                    default:          state_d = C_FETCH;
                endcase
            end
            C_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.op == C_OP_SW) ? C_MEMWR : C_MEMRD;
            end
            C_MEMRD: begin
                iord    = 1'b1;
                state_d = C_MEMWB;
            end
            C_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            C_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            C_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = C_ALUOP_FUNCT;
                state_d = C_RTYPEWB;
            end
            C_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            C_BEQEX: begin
                alusrca = 1'b1;
                aluop   = C_ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            C_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = C_ADDIWB;
            end
            C_ADDIWB: regwrite = 1'b1;
            C_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            // Unreachable encodings drive nothing and fall back to FETCH.
            default: legal_state = 1'b0;
        endcase
    end

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (aludec_out)
    );

    assign bus.pcen       = pcwrite | (branch & bus.zero);
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.iord       = iord;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = legal_state ? aludec_out : 3'b000;
    assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module  : tb_multicycle_controller
// Purpose : Scoreboard bench: per-cycle expected control words queued by the
//           stimulus, popped and compared by a negedge monitor.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       pcen, memwrite, irwrite, regwrite;
        logic       alusrca, iord, memtoreg, regdst;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    logic  clk = 1'b0;
    logic  reset;
    ctrl_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    mc_ctrl_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t actual();
        ctrl_t a;
        a = '{bus.state, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
              bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
              bus.alusrcb, bus.pcsrc, bus.alucontrol};
        return a;
    endfunction

    // Hand-written control table, one row per state.
    function automatic ctrl_t model(input logic [3:0] st, input logic [5:0] fn,
                                    input logic z);
        ctrl_t e;
        e = '0;
        e.state      = st;
        e.alucontrol = 3'b010;
        case (st)
            4'd0:  begin e.pcen = 1; e.irwrite = 1; e.alusrcb = 2'b01; end
            4'd1:  e.alusrcb = 2'b11;
            4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd3:  e.iord = 1;
            4'd4:  begin e.memtoreg = 1; e.regwrite = 1; end
            4'd5:  begin e.iord = 1; e.memwrite = 1; end
            4'd6: begin
                e.alusrca = 1;
                case (fn)
                    6'b100010: e.alucontrol = 3'b110;
                    6'b100100: e.alucontrol = 3'b000;
                    6'b100101: e.alucontrol = 3'b001;
                    6'b101010: e.alucontrol = 3'b111;
                    default:   e.alucontrol = 3'b010;
                endcase
            end
            4'd7:  begin e.regdst = 1; e.regwrite = 1; end
            4'd8:  begin e.alusrca = 1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; e.pcen = z; end
            4'd9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            4'd10: e.regwrite = 1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1; end
            default: e.alucontrol = 3'b000;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input ctrl_t act, input ctrl_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle", actual(), exp_q.pop_front());
    end

    // Entered and left one step after a rising edge, with the FSM in FETCH.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int n, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3,
                       input logic [3:0] s4);
        logic [3:0] seq [5];
        seq = '{s0, s1, s2, s3, s4};
        bus.op    = op;
        bus.funct = fn;
        bus.zero  = z;
        for (int i = 0; i < n; i++) exp_q.push_back(model(seq[i], fn, z));
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        bus.op    = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        #2;
        check("reset_async", actual(), model(4'd0, 6'd0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", actual(), model(4'd0, 6'd0, 1'b0));
        reset = 1'b0;

        run(6'b100011, 6'd0, 1'b0, 5, 0, 1, 2, 3, 4);
        run(6'b101011, 6'd0, 1'b1, 4, 0, 1, 2, 5, 0);
        run(6'b000000, 6'b100000, 1'b0, 4, 0, 1, 6, 7, 0);
        run(6'b000000, 6'b100010, 1'b0, 4, 0, 1, 6, 7, 0);
        run(6'b000000, 6'b100100, 1'b0, 4, 0, 1, 6, 7, 0);
        run(6'b000000, 6'b100101, 1'b0, 4, 0, 1, 6, 7, 0);
        run(6'b000000, 6'b101010, 1'b0, 4, 0, 1, 6, 7, 0);
        run(6'b000000, 6'b111111, 1'b0, 4, 0, 1, 6, 7, 0);
        run(6'b000100, 6'd0, 1'b1, 3, 0, 1, 8, 0, 0);
        run(6'b000100, 6'd0, 1'b0, 3, 0, 1, 8, 0, 0);
        run(6'b001000, 6'd0, 1'b0, 4, 0, 1, 9, 10, 0);
        run(6'b000010, 6'd0, 1'b1, 3, 0, 1, 11, 0, 0);
        run(6'b111111, 6'd0, 1'b0, 2, 0, 1, 0, 0, 0);

        // lw aborted by reset asserted between edges while in MEMRD.
        bus.op = 6'b100011;
        exp_q.push_back(model(4'd0, 6'd0, 1'b0));
        exp_q.push_back(model(4'd1, 6'd0, 1'b0));
        exp_q.push_back(model(4'd2, 6'd0, 1'b0));
        repeat (3) @(posedge clk);
        #2;
        check("pre_abort", actual(), model(4'd3, 6'd0, 1'b0));
        reset = 1'b1;
        #1;
        check("abort_async", actual(), model(4'd0, 6'd0, 1'b0));
        @(posedge clk);
        #2;
        check("abort_held", actual(), model(4'd0, 6'd0, 1'b0));
        reset = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(model(4'(i), 6'd0, 1'b0));
        repeat (5) @(posedge clk);
        #1;
        check("post_abort", actual(), model(4'd0, 6'd0, 1'b0));

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
